// File: rtl/seg_pkg.sv
// Shared types for the 7-segment animation path: animation/frame indices and sequencer states.
package seg_pkg;
    typedef logic [5:0] ani_t;
    typedef logic [5:0] frame_t;

    localparam ani_t LAST_ANI_DEFAULT = 6'd60;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } seq_state_e;

    // A zero frame count from the lookup is treated as a single-frame animation.
    function automatic frame_t eff_limit(input frame_t limit);
        return (limit == '0) ? frame_t'(1) : limit;
    endfunction
endpackage

// File: rtl/frame_sequencer_if.sv
// Control/status bundle between the frame sequencer and its surroundings (switches, limit lookup, ROM).
interface frame_sequencer_if;
    import seg_pkg::*;

    ani_t       sel;
    logic [1:0] speed;
    logic       pause;
    logic       auto;
    frame_t     limit;
    ani_t       animation;
    frame_t     frame;
    logic       step;
    logic       wrap;

    modport master (
        input  sel, speed, pause, auto, limit,
        output animation, frame, step, wrap
    );

    modport slave (
        output sel, speed, pause, auto, limit,
        input  animation, frame, step, wrap
    );
endinterface

// File: rtl/frame_sequencer_prescaler.sv
// Rate prescaler: counts to (CLK_DIV >> speed) - 1 and raises tick for one cycle at the terminal count.
module rate_prescaler #(
    parameter int               DIV_W   = 24,
    parameter logic [DIV_W-1:0] CLK_DIV = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       clr,
    input  logic [1:0] speed,
    output logic       tick
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] period;
    logic [DIV_W-1:0] term;

    assign period = CLK_DIV >> speed;
    assign term   = (period == '0) ? '0 : period - 1'b1;

    // >= so that a speed increase with the count already past the new terminal fires once, not wraps.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            if (cnt_q >= term) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/frame_sequencer.sv
// Frame-stepping engine: owns the animation index, steps the frame counter at a programmable rate.
// Optional auto-cycling of animations on wrap is built when FRAME_SEQ_AUTO_CYCLE_EN is defined.
module frame_sequencer
    import seg_pkg::*;
#(
    parameter int               DIV_W    = 24,
    parameter logic [DIV_W-1:0] CLK_DIV  = 24'd10_000_000,
    parameter ani_t             LAST_ANI = LAST_ANI_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    frame_sequencer_if.master    bus
);
    seq_state_e state_q, state_d;
    ani_t       animation_q, animation_d;
    frame_t     frame_q, frame_d;
    logic       step_q, step_d;
    logic       wrap_q, wrap_d;

    logic       auto_mode;
    logic       run_en;
    logic       sel_load;
    logic       tick;
    frame_t     lim;
    logic [6:0] frame_inc;

`ifdef FRAME_SEQ_AUTO_CYCLE_EN
    assign auto_mode = bus.auto;
`else
    assign auto_mode = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (bus.pause)  state_d = ST_HOLD;
            ST_HOLD: if (!bus.pause) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // The raw pause level also gates counting so a pause stops steps from the very next edge.
    assign run_en   = (state_q == ST_RUN) && !bus.pause;
    assign sel_load = !auto_mode && (bus.sel != animation_q);

    rate_prescaler #(
        .DIV_W   (DIV_W),
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run_en),
        .clr   (sel_load),
        .speed (bus.speed),
        .tick  (tick)
    );

    assign lim       = eff_limit(bus.limit);
    assign frame_inc = {1'b0, frame_q} + 7'd1;

    always_comb begin
        animation_d = animation_q;
        frame_d     = frame_q;
        step_d      = 1'b0;
        wrap_d      = 1'b0;
        if (sel_load) begin
            animation_d = bus.sel;
            frame_d     = '0;
        end else if (tick) begin
            step_d = 1'b1;
            if (frame_inc >= {1'b0, lim}) begin
                frame_d = '0;
                wrap_d  = 1'b1;
                if (auto_mode)
                    animation_d = (animation_q >= LAST_ANI) ? ani_t'(0) : animation_q + 1'b1;
            end else begin
                frame_d = frame_inc[5:0];
            end
        end else if (frame_q >= lim) begin
            // Limit shrank under us (new animation data); restart silently.
            frame_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            animation_q <= '0;
            frame_q     <= '0;
            step_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            animation_q <= animation_d;
            frame_q     <= frame_d;
            step_q      <= step_d;
            wrap_q      <= wrap_d;
        end
    end

    assign bus.animation = animation_q;
    assign bus.frame     = frame_q;
    assign bus.step      = step_q;
    assign bus.wrap      = wrap_q;
endmodule
